// File: rtl/a2d_scanner_if.sv
// A2D converter handshake: the scanner requests conversions, the converter
// returns a level completion flag with the 12-bit result.
interface a2d_scanner_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    modport master (output strt_cnv, chnnl, input cnv_cmplt, res);
    modport slave  (input strt_cnv, chnnl, output cnv_cmplt, res);
endinterface

// File: rtl/a2d_scanner.sv
// Periodic multi-channel A2D scanner with per-channel IIR smoothing,
// conversion timeout and scan-overrun detection.
module a2d_scanner #(
    parameter int SCAN_PERIOD = 50000,
    parameter int NUM_CH      = 3,
    parameter int AVG_SHIFT   = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    a2d_scanner_if.master      a2d,
    input  logic [2:0]         rd_ch,
    output logic [11:0]        rd_data,
    output logic [7:0]         vld,
    output logic               scan_done,
    output logic               err
);

    localparam int CNT_W = $clog2(SCAN_PERIOD + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [3:0]       NUM_CH_L = 4'(NUM_CH);
    localparam logic [3:0]       LAST_CH  = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // avg + ((smp - avg) >>> AVG_SHIFT); the step never overshoots smp, so the
    // sum stays inside the 12-bit unsigned range.
    function automatic logic [11:0] iir_step(input logic [11:0] avg, input logic [11:0] smp);
        logic signed [12:0] diff;
        logic signed [12:0] step;
        logic signed [13:0] sum;
        diff = $signed({1'b0, smp}) - $signed({1'b0, avg});
        step = diff >>> AVG_SHIFT;
        sum  = $signed({2'b00, avg}) + $signed({step[12], step});
        return sum[11:0];
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [2:0]       idx_r;
    logic             cmplt_prev_r;
    logic             strt_cnv_r;
    logic [2:0]       chnnl_r;
    logic             scan_done_r;
    logic             err_r;
    logic [7:0]       vld_r;
    logic [11:0]      avg_r [8];
    logic             wrap_s;
    logic             cmplt_s;
    logic             last_ch_s;

    assign wrap_s    = en && (cnt_r == CNT_LAST);
    assign cmplt_s   = a2d.cnv_cmplt && !cmplt_prev_r;
    assign last_ch_s = ({1'b0, idx_r} >= LAST_CH);

    assign a2d.strt_cnv = strt_cnv_r;
    assign a2d.chnnl    = chnnl_r;
    assign scan_done    = scan_done_r;
    assign err          = err_r;
    assign vld          = vld_r;

    // Read-back mux; channels outside the scanned set read as zero.
    always_comb begin
        rd_data = 12'd0;
        if ({1'b0, rd_ch} < NUM_CH_L) begin
            rd_data = avg_r[rd_ch];
        end else begin
            rd_data = 12'd0;
        end
    end

    // Scan period counter, held at zero while scanning is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!en || (cnt_r == CNT_LAST)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Previous completion level so only a fresh rising edge counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmplt_prev_r <= 1'b0;
        end else begin
            cmplt_prev_r <= a2d.cnv_cmplt;
        end
    end

    // Scan sequencer, filter bank and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= 3'd0;
            tmo_cnt_r   <= '0;
            strt_cnv_r  <= 1'b0;
            chnnl_r     <= 3'd0;
            scan_done_r <= 1'b0;
            err_r       <= 1'b0;
            vld_r       <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                avg_r[i] <= 12'd0;
            end
        end else begin
            strt_cnv_r  <= 1'b0;
            scan_done_r <= 1'b0;
            // A period tick that arrives mid-scan is dropped as an overrun.
            if (wrap_s && (state_r != IDLE)) begin
                err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (wrap_s) begin
                        state_r    <= START;
                        idx_r      <= 3'd0;
                        strt_cnv_r <= 1'b1;
                        chnnl_r    <= 3'd0;
                    end
                end
                START: begin
                    state_r   <= WAIT;
                    tmo_cnt_r <= '0;
                end
                WAIT: begin
                    if (cmplt_s || (tmo_cnt_r == TMO_LAST)) begin
                        if (cmplt_s) begin
                            if (vld_r[idx_r]) begin
                                avg_r[idx_r] <= iir_step(avg_r[idx_r], a2d.res);
                            end else begin
                                avg_r[idx_r] <= a2d.res;
                                vld_r[idx_r] <= 1'b1;
                            end
                        end else begin
                            err_r <= 1'b1;
                        end
                        if (!en) begin
                            state_r <= IDLE;
                        end else if (!last_ch_s) begin
                            state_r    <= START;
                            idx_r      <= idx_r + 3'd1;
                            strt_cnv_r <= 1'b1;
                            chnnl_r    <= idx_r + 3'd1;
                        end else begin
                            state_r     <= IDLE;
                            scan_done_r <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_scanner.sv
// Three scanners (periods 100, 2000, 30) each driven by a behavioural A2D model;
// a scoreboard queue holds the expected sequence of conversion requests.
module tb_a2d_scanner;

    logic            clk;
    logic            rst_n;
    logic [2:0]      en_s;
    logic [2:0][2:0] rd_ch_s;
    logic [2:0][11:0] rd_data_s;
    logic [2:0][7:0] vld_s;
    logic [2:0]      scan_done_s;
    logic [2:0]      err_s;
    logic [2:0]      strt_s;
    logic [2:0][2:0] chnnl_s;
    logic [11:0]     res_tab [3][3];
    int              skip_ch [3];
    int              exp_q [$];
    int              done_cnt [3];
    int              n_cmp;
    int              n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        a2d_scanner_if bus ();

        a2d_scanner #(
            .SCAN_PERIOD (g == 0 ? 100 : (g == 1 ? 2000 : 30)),
            .NUM_CH      (3),
            .AVG_SHIFT   (2),
            .TIMEOUT     (1023)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en_s[g]),
            .a2d       (bus),
            .rd_ch     (rd_ch_s[g]),
            .rd_data   (rd_data_s[g]),
            .vld       (vld_s[g]),
            .scan_done (scan_done_s[g]),
            .err       (err_s[g])
        );

        assign strt_s[g]  = bus.strt_cnv;
        assign chnnl_s[g] = bus.chnnl;

        // Converter model: completes 20 clocks after a request unless told to hang.
        initial begin : model
            int         cnt;
            logic       busy;
            logic [2:0] ch;
            cnt = 0;
            busy = 1'b0;
            ch = 3'd0;
            bus.cnv_cmplt = 1'b0;
            bus.res = 12'd0;
            forever begin
                @(negedge clk);
                if (bus.strt_cnv) begin
                    bus.cnv_cmplt = 1'b0;
                    busy = 1'b1;
                    cnt = 0;
                    ch = bus.chnnl;
                end else if (busy) begin
                    cnt++;
                    if (cnt == 20) begin
                        busy = 1'b0;
                        if (int'(ch) != skip_ch[g]) begin
                            bus.res = res_tab[g][ch];
                            bus.cnv_cmplt = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input int g, input logic [2:0] ch, input logic [11:0] exp, input string tag);
        rd_ch_s[g] = ch;
        #1;
        check(tag, 32'(rd_data_s[g]), 32'(exp));
    endtask

    task automatic wait_done(input int g, input int max, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done_s[g] && (n < max));
        check(tag, 32'(scan_done_s[g]), 32'd1);
    endtask

    task automatic wait_strt(input int g, input logic [2:0] ch, input int max, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(strt_s[g] && (chnnl_s[g] == ch)) && (n < max));
        check(tag, 32'(strt_s[g] && (chnnl_s[g] == ch)), 32'd1);
    endtask

    // Scoreboard: every request is popped against the expected queue.
    initial begin : monitor
        logic [2:0] prev_strt;
        int         e;
        prev_strt = 3'b000;
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst_n && strt_s[i]) begin
                    check("strt_back_to_back", 32'(prev_strt[i]), 32'd0);
                    check("strt_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("strt_chnnl", 32'(i * 8 + int'(chnnl_s[i])), 32'(e));
                    end
                end
                if (rst_n && scan_done_s[i]) done_cnt[i]++;
                prev_strt[i] = strt_s[i];
            end
        end
    end

    initial begin : stim
        int n;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en_s = 3'b000;
        rd_ch_s = '0;
        for (int i = 0; i < 3; i++) begin
            skip_ch[i] = (i == 1) ? 1 : -1;
            for (int j = 0; j < 3; j++) res_tab[i][j] = 12'h800;
        end
        repeat (3) @(negedge clk);
        check("rst_strt", 32'(strt_s[0]), 32'd0);
        check("rst_chnnl", 32'(chnnl_s[0]), 32'd0);
        check("rst_vld", 32'(vld_s[0]), 32'd0);
        check("rst_err", 32'(err_s[0]), 32'd0);
        check("rst_done", 32'(scan_done_s[0]), 32'd0);
        check_rd(0, 3'd0, 12'h000, "rst_rd0");
        rst_n = 1'b1;

        // First scan: every channel loads 0x800 directly.
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        en_s[0] = 1'b1;
        wait_done(0, 400, "scan1_done");
        #1;
        check("scan1_vld", 32'(vld_s[0]), 32'h07);
        check_rd(0, 3'd0, 12'h800, "scan1_rd0");
        check_rd(0, 3'd1, 12'h800, "scan1_rd1");
        check_rd(0, 3'd2, 12'h800, "scan1_rd2");
        check_rd(0, 3'd3, 12'h000, "rd_ch3_zero");
        check_rd(0, 3'd7, 12'h000, "rd_ch7_zero");
        check("scan1_err", 32'(err_s[0]), 32'd0);
        check("scan1_done_cnt", 32'(done_cnt[0]), 32'd1);
        check("scan1_q_empty", 32'(exp_q.size()), 32'd0);

        // Second scan: ch0 sees 0xC00, filtered 0x800 + 0x400/4.
        res_tab[0][0] = 12'hC00;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        wait_done(0, 300, "scan2_done");
        en_s[0] = 1'b0;
        #1;
        check_rd(0, 3'd0, 12'h900, "scan2_rd0");
        check_rd(0, 3'd1, 12'h800, "scan2_rd1");
        check("scan2_err", 32'(err_s[0]), 32'd0);
        check("scan2_done_cnt", 32'(done_cnt[0]), 32'd2);
        check("scan2_q_empty", 32'(exp_q.size()), 32'd0);

        // Converter hangs on ch1: err after the START clock plus 1023 WAIT clocks.
        exp_q.push_back(8); exp_q.push_back(9); exp_q.push_back(10);
        en_s[1] = 1'b1;
        wait_strt(1, 3'd1, 2200, "tmo_ch1_start");
        n = 0;
        while (!err_s[1] && (n < 1200)) begin
            @(negedge clk);
            n++;
        end
        check("tmo_err_clocks", 32'(n), 32'd1024);
        check("tmo_err", 32'(err_s[1]), 32'd1);
        wait_done(1, 100, "tmo_done");
        en_s[1] = 1'b0;
        #1;
        check("tmo_vld", 32'(vld_s[1]), 32'h05);
        check_rd(1, 3'd1, 12'h000, "tmo_rd1");
        check_rd(1, 3'd2, 12'h800, "tmo_rd2");
        check("tmo_done_cnt", 32'(done_cnt[1]), 32'd1);
        check("tmo_q_empty", 32'(exp_q.size()), 32'd0);

        // Period 30 against ~66-clock scans: wraps dropped, no extra requests.
        exp_q.push_back(16); exp_q.push_back(17); exp_q.push_back(18);
        en_s[2] = 1'b1;
        wait_done(2, 200, "ovr_done");
        en_s[2] = 1'b0;
        #1;
        check("ovr_err", 32'(err_s[2]), 32'd1);
        check("ovr_vld", 32'(vld_s[2]), 32'h07);
        check("ovr_done_cnt", 32'(done_cnt[2]), 32'd1);
        repeat (40) @(negedge clk);
        check("ovr_q_empty", 32'(exp_q.size()), 32'd0);

        // en dropped during ch1 WAIT: ch1 stored, no ch2, no scan_done.
        res_tab[0][1] = 12'h400;
        exp_q.push_back(0); exp_q.push_back(1);
        en_s[0] = 1'b1;
        wait_strt(0, 3'd1, 300, "endrop_ch1_start");
        repeat (5) @(negedge clk);
        en_s[0] = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check_rd(0, 3'd0, 12'h9C0, "endrop_rd0");
        check_rd(0, 3'd1, 12'h700, "endrop_rd1");
        check_rd(0, 3'd2, 12'h800, "endrop_rd2");
        check("endrop_done_cnt", 32'(done_cnt[0]), 32'd2);
        check("endrop_q_empty", 32'(exp_q.size()), 32'd0);

        // Counter held at 0: next request exactly one full period after re-enable.
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        n = 0;
        en_s[0] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!strt_s[0] && (n < 200));
        check("restart_clocks", 32'(n), 32'd100);

        // Reset during ch1 WAIT, then the stale completion must be ignored.
        wait_strt(0, 3'd1, 100, "rst_ch1_start");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        en_s[0] = 1'b0;
        #1;
        check("rstw_strt", 32'(strt_s[0]), 32'd0);
        check("rstw_chnnl", 32'(chnnl_s[0]), 32'd0);
        check("rstw_vld", 32'(vld_s[0]), 32'd0);
        check("rstw_err", 32'(err_s[0]), 32'd0);
        check_rd(0, 3'd0, 12'h000, "rstw_rd0");
        check_rd(0, 3'd1, 12'h000, "rstw_rd1");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("post_rst_vld", 32'(vld_s[0]), 32'd0);
        check_rd(0, 3'd1, 12'h000, "post_rst_rd1");
        check("post_rst_err", 32'(err_s[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
